div_counter: RTL and testbench

DIV_COUNTER -- requirements
Module: div_counter

---
 rtl/div_counter_pkg.sv | 34 +++
 rtl/div_counter_ext_edge_sync.sv | 36 +++
 rtl/div_counter.sv | 193 +++++++++++++++++++
 tb/tb_div_counter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_counter_pkg.sv
// div_counter_pkg
//   Shared definitions for the div_counter block: counter widths, FSM state
//   encoding, the miss limit that drops a frame back to alignment, and the
//   minimum effective N/M values together with the clamp helpers that apply them.
package div_counter_pkg;

  localparam int N_W    = 4;
  localparam int M_W    = 2;
  localparam int MISS_W = 2;

  // Consecutive frame wraps without a reference edge before re-aligning.
  localparam logic [MISS_W-1:0] MISS_LIMIT = 2'd2;
  localparam logic [MISS_W-1:0] MISS_ONE   = 2'd1;

  // Smallest usable period lengths; smaller requests are clamped up.
  localparam logic [N_W-1:0] N_MIN = 4'd2;
  localparam logic [M_W-1:0] M_MIN = 2'd1;
  localparam logic [N_W-1:0] N_ONE = 4'd1;
  localparam logic [M_W-1:0] M_ONE = 2'd1;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] n);
    return (n < N_MIN) ? N_MIN : n;
  endfunction

  function automatic logic [M_W-1:0] clamp_m(input logic [M_W-1:0] m);
    return (m < M_MIN) ? M_MIN : m;
  endfunction

endpackage

// File: rtl/div_counter_ext_edge_sync.sv
// ext_edge_sync
//   Brings the asynchronous reference clock into the clk_out domain through a
//   two-flop synchronizer and flags its rising edge with a one-cycle pulse.
// Ports
//   clk_out  : in  - sampling clock
//   rst      : in  - synchronous active-high reset, clears all flops
//   clk_ext  : in  - asynchronous reference, treated as data
//   ext_rise : out - one-cycle pulse on a synchronized rising edge of clk_ext
module ext_edge_sync (
  input  logic clk_out,
  input  logic rst,
  input  logic clk_ext,
  output logic ext_rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_out) begin
    // NOTE: flops are written with non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= clk_ext;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign ext_rise = sync_q & ~prev_q;

endmodule

// File: rtl/div_counter.sv
// div_counter
//   Frame counter running on the DLL output clock and aligned to an external
//   reference. Each frame is M_act periods of N_act cycles. The frame start is
//   pinned to synchronized clk_ext rising edges; consecutive on-time edges
//   build up lock, off-time edges realign the frame, and repeated missing edges
//   send the counter back to alignment.
// Ports
//   clk_out   : in  - clock, all state on its rising edge
//   rst       : in  - synchronous active-high reset
//   clk_ext   : in  - asynchronous reference, sampled as data
//   en        : in  - run enable; low forces IDLE
//   N         : in  - requested cycles per divided period (clamped to >= 2)
//   M         : in  - requested periods per frame (clamped to >= 1)
//   N_counter : out - position within the current period
//   M_counter : out - period index within the current frame
//   DIV_N     : out - high for the first half of each period
//   DIV_M     : out - high during the last period of the frame
//   locked    : out - frame aligned to clk_ext for LOCK_TARGET edges in a row
module div_counter
  import div_counter_pkg::*;
#(
  parameter int LOCK_TARGET = 3
) (
  input  logic           clk_out,
  input  logic           rst,
  input  logic           clk_ext,
  input  logic           en,
  input  logic [N_W-1:0] N,
  input  logic [M_W-1:0] M,
  output logic [N_W-1:0] N_counter,
  output logic [M_W-1:0] M_counter,
  output logic           DIV_N,
  output logic           DIV_M,
  output logic           locked
);

  localparam int              LOCK_W   = $clog2(LOCK_TARGET + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_TARGET);
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

  logic ext_rise;

  ext_edge_sync u_sync (
    .clk_out  (clk_out),
    .rst      (rst),
    .clk_ext  (clk_ext),
    .ext_rise (ext_rise)
  );

  logic [1:0]        state_q,  state_d;
  logic [N_W-1:0]    n_q,      n_nx;
  logic [M_W-1:0]    m_q,      m_nx;
  logic [N_W-1:0]    n_act_q,  n_act_d;
  logic [M_W-1:0]    m_act_q,  m_act_d;
  logic [LOCK_W-1:0] lock_q,   lock_d;
  logic [MISS_W-1:0] miss_q,   miss_d;
  logic              seen_q,   seen_d;
  logic              div_n_q,  div_m_q, locked_q;
  logic              counting;

  logic n_wrap, m_wrap, frame_wrap, frame_start;

  assign n_wrap      = (n_q == n_act_q - N_ONE);
  assign m_wrap      = (m_q == m_act_q - M_ONE);
  assign frame_wrap  = n_wrap && m_wrap;
  assign frame_start = (n_q == '0) && (m_q == '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no branch
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    n_act_d  = n_act_q;
    m_act_d  = m_act_q;
    lock_d   = '0;
    miss_d   = '0;
    seen_d   = 1'b0;
    counting = 1'b0;
    n_nx     = '0;
    m_nx     = '0;

    if (!en) begin
      state_d = ST_IDLE;
      n_act_d = clamp_n(N);
      m_act_d = clamp_m(M);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ALIGN;
          n_act_d = clamp_n(N);
          m_act_d = clamp_m(M);
        end

        ST_ALIGN: begin
          n_act_d = clamp_n(N);
          m_act_d = clamp_m(M);
          // The edge cycle itself is position (0,0), so RUN opens at (1,0).
          if (ext_rise) begin
            state_d  = ST_RUN;
            seen_d   = 1'b1;
            counting = 1'b1;
            n_nx     = N_ONE;
          end
        end

        ST_RUN: begin
          counting = 1'b1;
          lock_d   = lock_q;
          miss_d   = miss_q;
          seen_d   = seen_q | ext_rise;

          // Requested sizes only take effect at a frame boundary.
          if (frame_wrap) begin
            n_act_d = clamp_n(N);
            m_act_d = clamp_m(M);
          end

          if (ext_rise && !frame_start) begin
            // Off-time edge: this cycle becomes (0,0) and lock restarts.
            lock_d = '0;
            seen_d = 1'b1;
            n_nx   = N_ONE;
            m_nx   = '0;
          end else begin
            if (ext_rise) begin
              lock_d = (lock_q == LOCK_MAX) ? lock_q : lock_q + LOCK_ONE;
              miss_d = '0;
            end
            if (frame_wrap) begin
              seen_d = 1'b0;
              if (!seen_q) miss_d = miss_q + MISS_ONE;
            end
            if (n_wrap) begin
              n_nx = '0;
              m_nx = m_wrap ? '0 : m_q + M_ONE;
            end else begin
              n_nx = n_q + N_ONE;
              m_nx = m_q;
            end
          end

          if (miss_d == MISS_LIMIT) begin
            state_d  = ST_ALIGN;
            counting = 1'b0;
            lock_d   = '0;
            miss_d   = '0;
            seen_d   = 1'b0;
            n_nx     = '0;
            m_nx     = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered alongside the counter value they describe, using
  // the period sizes that will be in force for that value.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      m_q      <= '0;
      n_act_q  <= N_MIN;
      m_act_q  <= M_MIN;
      lock_q   <= '0;
      miss_q   <= '0;
      seen_q   <= 1'b0;
      div_n_q  <= 1'b0;
      div_m_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_nx;
      m_q      <= m_nx;
      n_act_q  <= n_act_d;
      m_act_q  <= m_act_d;
      lock_q   <= lock_d;
      miss_q   <= miss_d;
      seen_q   <= seen_d;
      div_n_q  <= counting && (n_nx < (n_act_d >> 1));
      div_m_q  <= counting && (m_nx == m_act_d - M_ONE);
      locked_q <= counting && (lock_d == LOCK_MAX);
    end
  end

  assign N_counter = n_q;
  assign M_counter = m_q;
  assign DIV_N     = div_n_q;
  assign DIV_M     = div_m_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_div_counter.sv
// tb_div_counter
//   Self-checking bench for div_counter. A frame-position model (one integer
//   position per frame, plus lock/miss bookkeeping) predicts every output each
//   cycle; directed scenarios add literal expectations on top of it, followed
//   by a randomized run.
module tb_div_counter;

  localparam int LOCK_TARGET = 3;

  logic       clk_out = 1'b0;
  logic       rst     = 1'b1;
  logic       clk_ext = 1'b0;
  logic       en      = 1'b0;
  logic [3:0] N       = 4'd4;
  logic [1:0] M       = 2'd2;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N;
  logic       DIV_M;
  logic       locked;

  int checks = 0;
  int errors = 0;

  div_counter #(.LOCK_TARGET(LOCK_TARGET)) dut (
    .clk_out   (clk_out),
    .rst       (rst),
    .clk_ext   (clk_ext),
    .en        (en),
    .N         (N),
    .M         (M),
    .N_counter (N_counter),
    .M_counter (M_counter),
    .DIV_N     (DIV_N),
    .DIV_M     (DIV_M),
    .locked    (locked)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ALIGN, M_RUN} mode_t;
  mode_t mode = M_IDLE;
  int    pos, nact, mact, lock_n, miss_n;
  bit    seen;
  bit    hist [3];          // [0] first sample, [1] second sample, [2] previous second
  bit    model_ok = 1'b0;
  int    exp_nc, exp_mc;
  bit    exp_dn, exp_dm, exp_lk;

  function automatic int clamp_i(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  always @(posedge clk_out) begin : model
    bit er, last, realign;
    if (rst) begin
      mode = M_IDLE; pos = 0; nact = 2; mact = 1;
      lock_n = 0; miss_n = 0; seen = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      model_ok = 1'b1;
    end else begin
      er = hist[1] && !hist[2];
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = clk_ext;
      if (!en) begin
        mode = M_IDLE; pos = 0; lock_n = 0; miss_n = 0; seen = 0;
        nact = clamp_i(int'(N), 2); mact = clamp_i(int'(M), 1);
      end else begin
        case (mode)
          M_IDLE: begin
            mode = M_ALIGN;
            nact = clamp_i(int'(N), 2); mact = clamp_i(int'(M), 1);
          end
          M_ALIGN: begin
            nact = clamp_i(int'(N), 2); mact = clamp_i(int'(M), 1);
            if (er) begin mode = M_RUN; pos = 1; seen = 1; end
          end
          default: begin
            last    = (pos == nact * mact - 1);
            realign = er && (pos != 0);
            if (last) begin
              nact = clamp_i(int'(N), 2); mact = clamp_i(int'(M), 1);
            end
            if (realign) begin
              lock_n = 0; pos = 1; seen = 1;
            end else begin
              if (er) begin
                if (lock_n < LOCK_TARGET) lock_n++;
                miss_n = 0; seen = 1;
              end
              if (last) begin
                if (!seen) miss_n++;
                seen = 0; pos = 0;
              end else begin
                pos++;
              end
            end
            if (miss_n >= 2) begin
              mode = M_ALIGN; pos = 0; lock_n = 0; miss_n = 0; seen = 0;
            end
          end
        endcase
      end
    end
    exp_nc = (mode == M_RUN) ? pos % nact : 0;
    exp_mc = (mode == M_RUN) ? pos / nact : 0;
    exp_dn = (mode == M_RUN) && ((pos % nact) < nact / 2);
    exp_dm = (mode == M_RUN) && ((pos / nact) == mact - 1);
    exp_lk = (mode == M_RUN) && (lock_n == LOCK_TARGET);
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk_out) begin
    if (model_ok) begin
      check("N_counter", 32'(N_counter), 32'(exp_nc));
      check("M_counter", 32'(M_counter), 32'(exp_mc));
      check("DIV_N",     32'(DIV_N),     32'(exp_dn));
      check("DIV_M",     32'(DIV_M),     32'(exp_dm));
      check("locked",    32'(locked),    32'(exp_lk));
    end
  end

  // ---------------- stimulus ----------------
  int cyc        = 0;
  int ext_period = 8;
  int ext_phase  = 0;
  bit ext_on     = 1'b0;

  task automatic step();
    @(negedge clk_out);
    #1;
    cyc++;
    clk_ext = ext_on && (((cyc + ext_phase) % ext_period) < (ext_period / 2));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_N_counter"}, 32'(N_counter), 32'd0);
    check({tag, "_M_counter"}, 32'(M_counter), 32'd0);
    check({tag, "_DIV_N"},     32'(DIV_N),     32'd0);
    check({tag, "_DIV_M"},     32'(DIV_M),     32'd0);
    check({tag, "_locked"},    32'(locked),    32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int exp_n [12];
    int k;
    bit found;

    // Reset state.
    steps(3);
    check_zero("reset");
    rst = 1'b0;

    // Locking at N=4, M=2 with an 8-cycle reference.
    N = 4'd4; M = 2'd2; ext_period = 8; ext_on = 1'b1; en = 1'b1;
    steps(60);
    check("lock_after_edges", 32'(locked), 32'd1);
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      if (N_counter == 4'd0 && M_counter == 2'd0 && DIV_N) found = 1;
      else step();
    end
    check("sync_frame_start", 32'(found), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("run_N_counter", 32'(N_counter), 32'(i % 4));
      check("run_M_counter", 32'(M_counter), 32'(i / 4));
      check("run_DIV_N",     32'(DIV_N),     32'((i % 4) < 2));
      check("run_DIV_M",     32'(DIV_M),     32'(i >= 4));
      step();
    end

    // Phase shift of the reference: lock drops, frame restarts, relocks.
    ext_phase = ext_phase + 3;
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      step();
      if (!locked) found = 1;
    end
    check("unlock_on_shift", 32'(found), 32'd1);
    check("realign_N_counter", 32'(N_counter), 32'd1);
    check("realign_M_counter", 32'(M_counter), 32'd0);
    steps(40);
    check("relock_after_shift", 32'(locked), 32'd1);

    // N change mid-frame takes effect only at the frame wrap.
    found = 0;
    for (k = 0; k < 20 && !found; k++) begin
      if (N_counter == 4'd1 && M_counter == 2'd0) found = 1;
      else step();
    end
    check("sync_n1", 32'(found), 32'd1);
    N = 4'd6;
    exp_n = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 4, 5};
    for (int i = 0; i < 12; i++) begin
      step();
      check("nchg_N_counter", 32'(N_counter), 32'(exp_n[i]));
      check("nchg_M_counter", 32'(M_counter), 32'((i >= 2 && i < 6) ? 1 : 0));
      check("nchg_DIV_N", 32'(DIV_N), 32'((i < 6) ? (exp_n[i] < 2) : (exp_n[i] < 3)));
    end

    // Stop the reference while locked: back to ALIGN after two empty wraps.
    en = 1'b0; N = 4'd4;
    step();
    en = 1'b1;
    steps(60);
    check("lock_before_stop", 32'(locked), 32'd1);
    ext_on = 1'b0;
    found = 0;
    for (k = 0; k < 40 && !found; k++) begin
      step();
      if (!locked) found = 1;
    end
    check("unlock_on_stop", 32'(found), 32'd1);
    check_zero("stopped");
    steps(5);
    check_zero("align_hold");

    // Clamped sizes: N=0, M=0 behave as N_act=2, M_act=1.
    N = 4'd0; M = 2'd0; ext_period = 4; ext_on = 1'b1;
    steps(30);
    found = 0;
    for (k = 0; k < 10 && !found; k++) begin
      if (DIV_N) found = 1;
      else step();
    end
    check("sync_clamped", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("clamp_DIV_N",     32'(DIV_N),     32'((i % 2) == 0));
      check("clamp_DIV_M",     32'(DIV_M),     32'd1);
      check("clamp_N_counter", 32'(N_counter), 32'(i % 2));
      check("clamp_locked",    32'(locked),    32'd1);
      step();
    end

    // One-cycle reset mid-RUN with en held high.
    rst = 1'b1;
    step();
    check_zero("midrun_rst");
    rst = 1'b0;
    step();
    check_zero("after_rst");

    // Randomized run against the model.
    N = 4'd4; M = 2'd2; ext_period = 8; ext_on = 1'b1; en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      rst = (r < 4);
      if (r >= 4 && r < 10) en = ~en;
      else if (r >= 10 && r < 35) begin
        N = 4'($urandom_range(0, 15));
        M = 2'($urandom_range(0, 3));
      end else if (r >= 35 && r < 42) begin
        if ($urandom_range(0, 1) == 1)
          ext_period = clamp_i(int'(N), 2) * clamp_i(int'(M), 1);
        else
          ext_period = 2 * int'($urandom_range(1, 12));
        ext_phase = int'($urandom_range(0, 23));
      end else if (r == 42) ext_on = ~ext_on;
      else if (r >= 43 && r < 50) en = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
